// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
// Optional build macro: UART_ARB_FIXED_PRI_EN (fixed priority instead of round-robin).
package uart_arb_pkg;

  localparam int unsigned StateW = 2;

  // Defaults used by the top-level parameters.
  localparam int unsigned DefNumReq       = 4;
  localparam int unsigned DefDataW        = 8;
  localparam int unsigned DefStartTimeout = 64;
  localparam int unsigned DefGapCycles    = 0;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the larger of the timeout and gap limits without wrapping.
  function automatic int unsigned cnt_width(input int unsigned timeout, input int unsigned gap);
    return $clog2(max_u(timeout, gap) + 1);
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner picker for the UART TX arbiter.
// Default: first asserted request searching upward from rr_ptr, wrapping.
// With UART_ARB_FIXED_PRI_EN defined: lowest asserted index wins and rr_ptr is absent.
module uart_arb_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
`ifndef UART_ARB_FIXED_PRI_EN
  input  logic [IdW-1:0]     rr_ptr,
`endif
  output logic [IdW-1:0]     winner,
  output logic               any_valid
);

  logic           found;
  logic [IdW-1:0] sel;
  int             idx;

  // Scan candidates in priority order and keep the first asserted one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef UART_ARB_FIXED_PRI_EN
      idx = k;
`else
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
`endif
      sel = IdW'(idx);
      if (!found && req_valid[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters. Each grant launches one
// byte with a one-cycle tx_start, then follows tx_busy until the frame ends, with an
// optional idle gap before the next grant and an abort if tx_busy never rises.
// Optional build macro: UART_ARB_FIXED_PRI_EN (fixed priority, no round-robin pointer).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned START_TIMEOUT = DefStartTimeout,
  parameter int unsigned GAP_CYCLES    = DefGapCycles,
  localparam int unsigned IdW          = id_width(NUM_REQ),
  localparam int unsigned CntW         = cnt_width(START_TIMEOUT, GAP_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IdW-1:0]            grant_id,
  output logic                      active,
  output logic                      err_timeout
);

  // Counter value on the last allowed cycle; the next increment would reach the limit.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(START_TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IdW-1:0]  LastId      = IdW'(NUM_REQ - 1);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic [IdW-1:0]  winner;
  logic            any_valid;

`ifndef UART_ARB_FIXED_PRI_EN
  logic [IdW-1:0]  rr_ptr;
`endif

  // Saturating increment so the counter never wraps.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  uart_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
`ifndef UART_ARB_FIXED_PRI_EN
    .rr_ptr    (rr_ptr),
`endif
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Arbitration FSM with registered strobes and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ready   <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
`ifndef UART_ARB_FIXED_PRI_EN
      rr_ptr      <= '0;
`endif
    end else begin
      tx_start    <= 1'b0;
      req_ready   <= '0;
      err_timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          // A transmitter still busy (e.g. after a reset mid-frame) blocks new grants.
          if (any_valid && !tx_busy) begin
            tx_data   <= req_data[winner*DATA_W +: DATA_W];
            tx_start  <= 1'b1;
            req_ready <= NUM_REQ'(1) << winner;
            grant_id  <= winner;
            active    <= 1'b1;
            cnt       <= '0;
            state     <= StWaitBusy;
`ifndef UART_ARB_FIXED_PRI_EN
            rr_ptr    <= (winner == LastId) ? '0 : winner + 1'b1;
`endif
          end
        end
        StWaitBusy: begin
          if (tx_busy) begin
            state <= StWaitDone;
          end else if (cnt == TimeoutLast) begin
            // Byte is dropped; the pointer keeps its advanced value.
            err_timeout <= 1'b1;
            active      <= 1'b0;
            state       <= StIdle;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            cnt <= '0;
            if (GAP_CYCLES > 0) begin
              state <= StGap;
            end else begin
              active <= 1'b0;
              state  <= StIdle;
            end
          end
        end
        StGap: begin
          if (cnt == GapLast) begin
            active <= 1'b0;
            state  <= StIdle;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a UART busy model drive the DUT, a
// separate monitor compares every grant, ack, timeout and activity edge against a
// timing/ordering reference model. Honours UART_ARB_FIXED_PRI_EN in the reference.
module tb_uart_tx_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 8;
  localparam int TO  = 64;
  localparam int GAP = 5;
  localparam int IDW = $clog2(NUM);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM-1:0]    req_valid = '0;
  logic [NUM*DW-1:0] req_data = '0;
  logic [NUM-1:0]    req_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy = 1'b0;
  logic [IDW-1:0]    grant_id;
  logic              active;
  logic              err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM),
    .DATA_W        (DW),
    .START_TIMEOUT (TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Environment state (driven only by the stimulus process).
  logic [DW-1:0]  drv_q[NUM][$];
  logic [DW-1:0]  exp_q[NUM][$];
  int             cyc = 0;
  logic [NUM-1:0] seen_valid = '0;
  logic           seen_busy = 1'b0;
  logic           seen_rst = 1'b1;
  int             u_phase = 0;
  int             u_cnt = 0;
  logic           uart_busy = 1'b0;
  logic           force_busy = 1'b0;
  bit             u_ignore_next = 1'b0;
  int             u_fix_delay = 0;
  int             u_fix_len = 0;
  int             ign_pct = 0;
  int             n_pushed = 0;
  int             n_starts = 0;

  // Reference model state (owned by the monitor).
  bit             m_idle = 1'b1;
  int             m_ptr = 0;
  int             ready_edge = 1;
  int             g_edge = 0;
  int             m_phase = 0;
  bit             act_pending = 1'b0;
  int             clear_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
  endtask

  function automatic int pick(input logic [NUM-1:0] v, input int ptr);
    logic [NUM-1:0] t;
    int start;
`ifdef UART_ARB_FIXED_PRI_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NUM; k++) begin
      int c;
      c = (start + k) % NUM;
      t = v >> c;
      if (t[0]) return c;
    end
    return -1;
  endfunction

  task automatic update_req();
    for (int i = 0; i < NUM; i++) begin
      req_valid[i] = (drv_q[i].size() > 0);
      req_data[i*DW +: DW] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] b);
    drv_q[ch].push_back(b);
    exp_q[ch].push_back(b);
    n_pushed++;
    update_req();
  endtask

  // One clock: snapshot what the DUT sampled, then update requesters and UART model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    seen_valid = req_valid;
    seen_busy  = tx_busy;
    seen_rst   = rst;
    for (int i = 0; i < NUM; i++) begin
      logic [NUM-1:0] r;
      r = req_ready >> i;
      if (r[0] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
    end
    case (u_phase)
      0: if (tx_start) begin
        if (u_ignore_next || ($urandom_range(99) < ign_pct)) begin
          u_ignore_next = 1'b0;
        end else begin
          u_phase = 1;
          u_cnt = (u_fix_delay > 0) ? u_fix_delay : int'($urandom_range(20, 3));
        end
      end
      1: begin
        u_cnt--;
        if (u_cnt == 0) begin
          uart_busy = 1'b1;
          u_phase = 2;
          u_cnt = (u_fix_len > 0) ? u_fix_len : int'($urandom_range(15, 4));
        end
      end
      default: begin
        u_cnt--;
        if (u_cnt == 0) begin
          uart_busy = 1'b0;
          u_phase = 0;
        end
      end
    endcase
    tx_busy = uart_busy | force_busy;
    update_req();
  endtask

  task automatic wait_idle(input int limit, input string name);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      tick();
      n++;
      done = 1'b1;
      for (int i = 0; i < NUM; i++) if (drv_q[i].size() > 0) done = 1'b0;
      if (u_phase != 0 || force_busy || !m_idle || act_pending || cyc <= ready_edge) done = 1'b0;
    end
    check(name, 64'(done), 64'd1);
  endtask

  // Monitor: compares DUT outputs against the reference model once per cycle.
  always @(negedge clk) begin
    int             w;
    bit             exp_start;
    bit             exp_to;
    logic [NUM-1:0] exp_rdy;
    logic [DW-1:0]  exp_b;
    if (seen_rst) begin
      check("reset_outs", 64'({tx_start, req_ready, tx_data, grant_id, active, err_timeout}),
            64'd0);
      m_idle = 1'b1;
      m_ptr = 0;
      ready_edge = cyc + 1;
      act_pending = 1'b0;
    end else begin
      exp_to = 1'b0;
      if (!m_idle) begin
        if (m_phase == 0) begin
          if (seen_busy) begin
            m_phase = 1;
          end else if (cyc - g_edge == TO) begin
            exp_to = 1'b1;
            m_idle = 1'b1;
            ready_edge = cyc + 1;
            check("active_timeout", 64'(active), 64'd0);
          end
        end else if (!seen_busy) begin
          m_idle = 1'b1;
          ready_edge = cyc + GAP + 1;
          clear_edge = cyc + GAP;
          act_pending = 1'b1;
        end
      end
      if (act_pending && cyc + 1 == clear_edge) check("active_gap", 64'(active), 64'd1);
      if (act_pending && cyc == clear_edge) begin
        check("active_clear", 64'(active), 64'd0);
        act_pending = 1'b0;
      end
      exp_start = m_idle && (cyc >= ready_edge) && (seen_valid != '0) && !seen_busy;
      if (tx_start) n_starts++;
      if (exp_start || tx_start || req_ready != '0) begin
        w = exp_start ? pick(seen_valid, m_ptr) : 0;
        exp_rdy = exp_start ? (NUM'(1) << w) : '0;
        check("start", 64'(tx_start), 64'(exp_start));
        check("ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_start) begin
          exp_b = '0;
          if (exp_q[w].size() > 0) exp_b = exp_q[w].pop_front();
          if (tx_start) begin
            check("grant_id", 64'(grant_id), 64'(w));
            check("data", 64'(tx_data), 64'(exp_b));
            check("active_grant", 64'(active), 64'd1);
          end
          m_idle = 1'b0;
          m_phase = 0;
          g_edge = cyc;
          m_ptr = (w + 1) % NUM;
        end
      end
      if (exp_to || err_timeout) check("err_timeout", 64'(err_timeout), 64'(exp_to));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single request on channel 2.
    push(2, 8'h5A);
    wait_idle(200, "single_done");

    // Fairness: every channel holds two bytes, fixed 10-cycle frames, fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_fix_delay = 2;
    u_fix_len = 10;
    for (int i = 0; i < NUM; i++) begin
      push(i, DW'(8'h10 + i));
      push(i, DW'(8'h20 + i));
    end
    wait_idle(800, "fair_done");

    // Start timeout: transmitter ignores one start, then the next request is served.
    u_ignore_next = 1'b1;
    push(1, 8'hC3);
    wait_idle(300, "timeout_done");
    push(3, 8'h3C);
    wait_idle(200, "after_timeout_done");

    // Gap between two pending channels.
    push(0, 8'hA1);
    push(3, 8'hB2);
    wait_idle(300, "gap_done");

    // Reset while the frame is in progress.
    u_fix_len = 12;
    push(1, 8'h77);
    push(2, 8'h88);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      tick();
      n++;
      hit = (u_phase == 2);
    end
    check("midframe_busy_seen", 64'(hit), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle(300, "midframe_done");

    // Transmitter busy while idle with a request pending.
    force_busy = 1'b1;
    tick();
    push(2, 8'h42);
    repeat (8) tick();
    force_busy = 1'b0;
    wait_idle(200, "busy_idle_done");

    // Randomised traffic with occasional ignored starts.
    u_fix_delay = 0;
    u_fix_len = 0;
    ign_pct = 5;
    repeat (400) begin
      tick();
      for (int i = 0; i < NUM; i++) begin
        if ($urandom_range(11) == 0 && drv_q[i].size() < 3) push(i, DW'($urandom));
      end
    end
    ign_pct = 0;
    wait_idle(4000, "drain");
    check("starts", 64'(n_starts), 64'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
